// File: rtl/mux4_rr_arbiter_if.sv
// Handshake bundle between four requesters, the arbiter and one downstream sink.
//   slave  : arbiter side. It takes the req_* and out_ready signals in and
//            drives req_ready, the out_* signals and busy.
//   master : environment side. It drives the requesters and the sink.
interface mux4_rr_arbiter_if #(
    parameter int DATA_W = 32
);
    logic [3:0]        req_valid;
    logic [3:0]        req_last;
    logic [DATA_W-1:0] req_data0;
    logic [DATA_W-1:0] req_data1;
    logic [DATA_W-1:0] req_data2;
    logic [DATA_W-1:0] req_data3;
    logic [3:0]        req_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic [1:0]        out_sel;
    logic              out_ready;
    logic              busy;

    modport slave (
        input  req_valid, req_last, req_data0, req_data1, req_data2, req_data3, out_ready,
        output req_ready, out_valid, out_data, out_last, out_sel, busy
    );

    modport master (
        output req_valid, req_last, req_data0, req_data1, req_data2, req_data3, out_ready,
        input  req_ready, out_valid, out_data, out_last, out_sel, busy
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Four-way round-robin burst arbiter with a single registered output stage.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mux4_rr_arbiter_if.slave. It carries the requester valid, last,
//           data and ready signals, the registered out_* beat with out_ready,
//           and busy.
// State table:
//   IDLE | arbitrating. No requester is granted and req_ready is 0000.
//   OWN  | the owner streams beats until it sends its last beat.
module mux4_rr_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mux4_rr_arbiter_if.slave      bus
);
    typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

    state_t            state;
    logic [1:0]        owner;
    logic [1:0]        ptr;
    logic [1:0]        grant;
    logic              found;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_last_q;
    logic [1:0]        out_sel_q;
    logic              can_load;
    logic              xfer;
    logic [DATA_W-1:0] own_data;
    logic [3:0]        ready;

    // The scan runs from the highest offset down, so the lowest offset from
    // ptr that has a request is the last one written and wins.
    always_comb begin
        logic [1:0] cand;
        grant = ptr;
        found = 1'b0;
        cand  = ptr;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (bus.req_valid[cand]) begin
                grant = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        case (owner)
            2'd0:    own_data = bus.req_data0;
            2'd1:    own_data = bus.req_data1;
            2'd2:    own_data = bus.req_data2;
            default: own_data = bus.req_data3;
        endcase
    end

    // The output register can take a new beat when it is empty or draining.
    assign can_load = !out_valid_q || bus.out_ready;
    assign xfer     = (state == OWN) && bus.req_valid[owner] && can_load;

    always_comb begin
        ready = 4'b0000;
        if (state == OWN && can_load) begin
            ready[owner] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner       <= 2'd0;
            ptr         <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_sel_q   <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        owner <= grant;
                        state <= OWN;
                    end
                end
                OWN: begin
                    if (xfer && bus.req_last[owner]) begin
                        state <= IDLE;
                        ptr   <= owner + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (xfer) begin
                out_valid_q <= 1'b1;
                out_data_q  <= own_data;
                out_last_q  <= bus.req_last[owner];
                out_sel_q   <= owner;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.busy      = (state == OWN);
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   cyc;

    mux4_rr_arbiter_if #(.DATA_W(32)) bus ();

    mux4_rr_arbiter #(.DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] data;
        logic        last;
    } exp_t;

    beat_t rq0[$];
    beat_t rq1[$];
    beat_t rq2[$];
    beat_t rq3[$];
    exp_t  exp_q[$];
    int    acc[$];
    exp_t  me;
    logic [3:0] hs;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic drive();
        bus.req_valid[0] = (rq0.size() != 0);
        bus.req_last[0]  = (rq0.size() != 0) ? rq0[0].last : 1'b0;
        bus.req_data0    = (rq0.size() != 0) ? rq0[0].data : 32'h0;
        bus.req_valid[1] = (rq1.size() != 0);
        bus.req_last[1]  = (rq1.size() != 0) ? rq1[0].last : 1'b0;
        bus.req_data1    = (rq1.size() != 0) ? rq1[0].data : 32'h0;
        bus.req_valid[2] = (rq2.size() != 0);
        bus.req_last[2]  = (rq2.size() != 0) ? rq2[0].last : 1'b0;
        bus.req_data2    = (rq2.size() != 0) ? rq2[0].data : 32'h0;
        bus.req_valid[3] = (rq3.size() != 0);
        bus.req_last[3]  = (rq3.size() != 0) ? rq3[0].last : 1'b0;
        bus.req_data3    = (rq3.size() != 0) ? rq3[0].data : 32'h0;
    endtask

    // Queues a beat on a requester and, if it is expected downstream, records
    // the response the sink should see for it.
    task automatic push(input int r, input logic [31:0] d, input logic l, input bit expect_out);
        beat_t b;
        exp_t  e;
        b.data = d;
        b.last = l;
        case (r)
            0: rq0.push_back(b);
            1: rq1.push_back(b);
            2: rq2.push_back(b);
            default: rq3.push_back(b);
        endcase
        if (expect_out) begin
            e.sel  = 2'(r);
            e.data = d;
            e.last = l;
            exp_q.push_back(e);
        end
    endtask

    task automatic flush();
        rq0.delete();
        rq1.delete();
        rq2.delete();
        rq3.delete();
        drive();
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #2;
    endtask

    // Requester model: a beat leaves its queue on each accepting edge.
    always begin
        @(posedge clk);
        hs = bus.req_valid & bus.req_ready;
        #1;
        if (hs[0] && rq0.size() != 0) void'(rq0.pop_front());
        if (hs[1] && rq1.size() != 0) void'(rq1.pop_front());
        if (hs[2] && rq2.size() != 0) void'(rq2.pop_front());
        if (hs[3] && rq3.size() != 0) void'(rq3.pop_front());
        drive();
    end

    // Scoreboard monitor: each beat accepted downstream is checked against the queue.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            acc.push_back(cyc);
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_extra: got sel=%0d data=%h last=%b want no beat",
                         bus.out_sel, bus.out_data, bus.out_last);
            end else begin
                me = exp_q.pop_front();
                if (bus.out_sel !== me.sel || bus.out_data !== me.data || bus.out_last !== me.last) begin
                    bad++;
                    $display("FAIL sb_beat: got sel=%0d data=%h last=%b want sel=%0d data=%h last=%b",
                             bus.out_sel, bus.out_data, bus.out_last, me.sel, me.data, me.last);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        drive();
        #3;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_busy",      64'(bus.busy), 64'd0);
        chk("rst_out_data",  64'(bus.out_data), 64'd0);
        chk("rst_out_sel",   64'(bus.out_sel), 64'd0);
        chk("rst_out_last",  64'(bus.out_last), 64'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Single beat from requester 1.
        push(1, 32'hDEADBEEF, 1'b1, 1'b1);
        drive();
        @(posedge clk); #2;
        chk("single_busy",  64'(bus.busy), 64'd1);
        chk("single_ready", 64'(bus.req_ready), 64'b0010);
        @(posedge clk); #2;
        chk("single_valid", 64'(bus.out_valid), 64'd1);
        chk("single_data",  64'(bus.out_data), 64'hDEADBEEF);
        chk("single_sel",   64'(bus.out_sel), 64'd1);
        chk("single_last",  64'(bus.out_last), 64'd1);
        chk("single_idle",  64'(bus.busy), 64'd0);
        wait_drain("single_drain");

        // Round robin from ptr 0: all requesters hold single-beat bursts.
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        acc.delete();
        push(0, 32'hA000_0000, 1'b1, 1'b1);
        push(1, 32'hA000_0011, 1'b1, 1'b1);
        push(2, 32'hA000_0022, 1'b1, 1'b1);
        push(3, 32'hA000_0033, 1'b1, 1'b1);
        push(0, 32'hA000_0044, 1'b1, 1'b1);
        drive();
        wait_drain("rr_drain");
        chk("rr_count", 64'(acc.size()), 64'd5);
        if (acc.size() == 5)
            for (int i = 1; i < 5; i++) chk("rr_gap", 64'(acc[i] - acc[i-1]), 64'd2);

        // Burst lock: requester 2 sends three beats while requester 0 waits.
        acc.delete();
        push(2, 32'hB200_0001, 1'b0, 1'b1);
        push(2, 32'hB200_0002, 1'b0, 1'b1);
        push(2, 32'hB200_0003, 1'b1, 1'b1);
        push(0, 32'hB000_0004, 1'b1, 1'b1);
        drive();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            chk("lock_ready", 64'(bus.req_ready), 64'b0100);
        end
        @(posedge clk); #2;
        chk("lock_idle_ready", 64'(bus.req_ready), 64'b0000);
        chk("lock_idle_busy",  64'(bus.busy), 64'd0);
        @(posedge clk); #2;
        chk("lock_next_ready", 64'(bus.req_ready), 64'b0001);
        wait_drain("lock_drain");
        chk("lock_count", 64'(acc.size()), 64'd4);
        if (acc.size() == 4) begin
            chk("lock_gap1", 64'(acc[1] - acc[0]), 64'd1);
            chk("lock_gap2", 64'(acc[2] - acc[1]), 64'd1);
            chk("lock_gap3", 64'(acc[3] - acc[2]), 64'd2);
        end

        // Backpressure on a six-beat burst from requester 3.
        acc.delete();
        for (int i = 0; i < 6; i++) push(3, 32'hC300_0000 + 32'(i), (i == 5), 1'b1);
        drive();
        @(posedge clk); #2;
        chk("bp_busy", 64'(bus.busy), 64'd1);
        @(posedge clk); #2;
        chk("bp_first", 64'(bus.out_data), 64'hC300_0000);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #2;
            chk("bp_frozen_data",  64'(bus.out_data), 64'hC300_0000);
            chk("bp_frozen_ready", 64'(bus.req_ready), 64'b0000);
        end
        bus.out_ready = 1'b1;
        wait_drain("bp_drain");
        chk("bp_count", 64'(acc.size()), 64'd6);
        if (acc.size() == 6)
            for (int i = 1; i < 6; i++) chk("bp_gap", 64'(acc[i] - acc[i-1]), 64'd1);

        // Wrap: requester 2 leaves ptr at 3, so 3 beats 0.
        push(2, 32'hD200_0000, 1'b1, 1'b1);
        drive();
        wait_drain("wrap_pre_drain");
        push(0, 32'hD000_0000, 1'b1, 1'b0);
        push(3, 32'hD300_0000, 1'b1, 1'b1);
        begin
            exp_t e;
            e.sel = 2'd0; e.data = 32'hD000_0000; e.last = 1'b1;
            exp_q.push_back(e);
        end
        drive();
        wait_drain("wrap_drain");

        // Reset mid-burst of requester 1.
        push(1, 32'hE100_0000, 1'b0, 1'b1);
        push(1, 32'hE100_0001, 1'b0, 1'b0);
        push(1, 32'hE100_0002, 1'b0, 1'b0);
        push(1, 32'hE100_0003, 1'b1, 1'b0);
        drive();
        repeat (3) @(posedge clk);
        #2;
        chk("mid_pre_data", 64'(bus.out_data), 64'hE100_0001);
        rst_n = 1'b0;
        #1;
        chk("mid_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_ready", 64'(bus.req_ready), 64'd0);
        chk("mid_busy",  64'(bus.busy), 64'd0);
        chk("mid_data",  64'(bus.out_data), 64'd0);
        chk("mid_sb_empty", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        flush();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        push(0, 32'hF000_0000, 1'b1, 1'b1);
        push(1, 32'hF100_0000, 1'b1, 1'b1);
        push(2, 32'hF200_0000, 1'b1, 1'b1);
        push(3, 32'hF300_0000, 1'b1, 1'b1);
        drive();
        @(posedge clk); #2;
        chk("post_rst_ready", 64'(bus.req_ready), 64'b0001);
        wait_drain("post_rst_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 Parameter: DATA_W, default 32, width of each requester data port and of out_data.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  4  bit i = requester i offers a beat.
REQ-005 req_last  input  4  bit i = offered beat of requester i ends its burst.
REQ-006 req_data0..req_data3  input  DATA_W each  requester 0..3 data.
REQ-007 req_ready  output  4  bit i = beat of requester i accepted this cycle when req_valid[i] also high.
REQ-008 out_valid  output  1  out_data/out_last/out_sel hold a valid beat.
REQ-009 out_data  output  DATA_W  registered selected beat.
REQ-010 out_last  output  1  registered req_last of that beat.
REQ-011 out_sel  output  2  index of requester that supplied the beat.
REQ-012 out_ready  input  1  downstream accepts beat when out_valid high.
REQ-013 busy  output  1  high while a requester owns the datapath (state OWN).

Function
REQ-014 Block SHALL implement two states, IDLE and OWN, plus a 2-bit owner register and a 2-bit round-robin pointer ptr.
REQ-015 IDLE: if req_valid != 0, the block SHALL select the first i with req_valid[i]=1 searching ptr, ptr+1, ptr+2, ptr+3 (mod 4), load owner=i and enter OWN next cycle; otherwise remain IDLE.
REQ-016 IDLE: req_ready SHALL be 0000; no beat transfers during the arbitration cycle (one-cycle arbitration latency).
REQ-017 OWN: req_ready[owner] SHALL equal (!out_valid | out_ready); all other req_ready bits SHALL be 0.
REQ-018 A beat transfers when req_valid[owner] & req_ready[owner]; the next edge SHALL load out_data=req_data<owner>, out_last=req_last[owner], out_sel=owner, out_valid=1.
REQ-019 When a transferred beat has req_last[owner]=1, the block SHALL return to IDLE and set ptr=owner+1 (mod 4, 3 wraps to 0) on the same edge.
REQ-020 OWN with req_valid[owner]=0 SHALL hold state and owner (bubble); other requesters SHALL NOT be granted mid-burst.
REQ-021 out_valid SHALL clear on an edge where out_valid & out_ready and no new beat loads; simultaneous drain and load SHALL keep out_valid=1 with new contents.
REQ-022 When out_valid=1 and out_ready=0, out_data/out_last/out_sel SHALL remain stable and req_ready SHALL be 0000.
REQ-023 Sustained throughput within a burst SHALL be one beat per cycle while out_ready=1.
REQ-024 Between bursts exactly one IDLE cycle SHALL occur; out_valid may stay high across it only for the final beat of the previous burst awaiting drain.
REQ-025 busy SHALL be 1 exactly when state is OWN.
REQ-026 Requests arriving in OWN from non-owners SHALL be considered only at the next IDLE cycle.

Reset
REQ-027 rst_n=0 SHALL immediately force: state IDLE, owner 0, ptr 0, out_valid 0, out_data 0, out_last 0, out_sel 0, req_ready 0000, busy 0, independent of clk.
REQ-028 Reset asserted mid-burst SHALL discard the held output beat and ownership; after release first arbitration starts from ptr=0.
REQ-029 Operation SHALL resume on the first rising clk edge after rst_n goes high.

Verification
REQ-030 Single beat: req_valid=0010, req_last=0010, req_data1=32'hDEADBEEF, out_ready=1 -> cycle+1 busy=1, req_ready=0010; cycle+2 out_valid=1, out_data=DEADBEEF, out_sel=1, out_last=1, state IDLE, ptr=2.
REQ-031 Round robin: all four valid with single-beat bursts continuously, out_ready=1 -> out_sel sequence 0,1,2,3,0 with one IDLE cycle between each.
REQ-032 Burst lock: requester 2 sends 3 beats (last on third) while requester 0 valid -> out_sel=2 for three beats, then requester 0 granted after one IDLE cycle; req_ready[0]=0 throughout burst.
REQ-033 Backpressure: owner 3 streaming, out_ready=0 for 4 cycles -> out_data frozen, req_ready=0000; on out_ready=1 beats resume one per cycle, none lost or duplicated.
REQ-034 Wrap: ptr=3 after owner 2 finishes, req_valid=1001 -> requester 3 granted; after its last beat ptr=0, next requester 0.
REQ-035 Reset mid-burst: assert rst_n=0 between edges during owner 1 burst -> out_valid, req_ready, busy fall to 0 without clock edge; after release req_valid=1111 grants requester 0.
